// File: rtl/bch_pkg.sv
// Code parameters shared by the BCH encoder and dec_top so both agree on
// the (141,127) code, plus the serial encoder's FSM states.
package bch_pkg;

    localparam int K     = 127;
    localparam int R     = 14;
    localparam int N     = K + R;
    localparam int CNT_W = $clog2(K);

    // g(x) = x^14+x^9+x^8+x^6+x^5+x^4+x^2+x+1
    localparam logic [R:0] GEN_POLY = 15'h4377;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } enc_state_e;

endpackage

// File: rtl/bch_lfsr_step.sv
// One-bit systematic-encoder LFSR update: r' = (r*x + d*x^R) mod g(x).
// Purely combinational; the serial encoder uses one, a parallel one chains several.
module bch_lfsr_step #(
    parameter int         R        = 14,
    parameter logic [R:0] GEN_POLY = 15'h4377
) (
    input  logic [R-1:0] r_i,
    input  logic         d_i,
    output logic [R-1:0] r_o
);

    logic fb;

    assign fb  = d_i ^ r_i[R-1];
    assign r_o = {r_i[R-2:0], 1'b0} ^ (fb ? GEN_POLY[R-1:0] : '0);

endmodule

// File: rtl/bch_enc_serial.sv
// Serial systematic BCH encoder: accepts a 127-bit word, shifts it MSB first
// through the parity LFSR over 127 cycles, then presents {data, parity}.
module bch_enc_serial
    import bch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_code,
    output logic         busy
);

    enc_state_e       state_q, state_d;
    logic [K-1:0]     data_q, data_d;
    logic [R-1:0]     lfsr_q, lfsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] bit_idx;
    logic [R-1:0]     lfsr_next;

    // Data register stays intact; the counter picks bits MSB first.
    assign bit_idx = CNT_W'(K - 1) - cnt_q;

    bch_lfsr_step #(
        .R        (R),
        .GEN_POLY (GEN_POLY)
    ) u_step (
        .r_i (lfsr_q),
        .d_i (data_q[bit_idx]),
        .r_o (lfsr_next)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    lfsr_d  = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                lfsr_d = lfsr_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(K - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            lfsr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
        end
    end

    // All outputs decode registered state only.
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign out_valid = (state_q == DONE);
    assign out_code  = {data_q, lfsr_q};

endmodule

// File: tb/tb_bch_enc_serial.sv
// Self-checking bench for bch_enc_serial: polynomial-division parity model,
// per-cycle handshake/timing checker, and directed literal vectors.
module tb_bch_enc_serial;

    localparam int          K  = 127;
    localparam int          R  = 14;
    localparam int          N  = K + R;
    localparam logic [R:0]  G  = 15'h4377;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [K-1:0] in_data = '0;
    logic         in_ready, out_valid, busy;
    logic [N-1:0] out_code;

    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    bit           pending = 1'b0;
    bit           chk_en = 1'b0;
    logic [N-1:0] exp_code = '0;

    bch_enc_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Parity = remainder of m(x)*x^R divided by g(x), by long division.
    function automatic logic [R-1:0] mpar(input logic [K-1:0] m);
        logic [N-1:0] p;
        p = {m, {R{1'b0}}};
        for (int i = N - 1; i >= R; i--) begin
            if (p[i]) p[i-:(R+1)] = p[i-:(R+1)] ^ G;
        end
        return p[R-1:0];
    endfunction

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Transaction monitor: records what was accepted and when.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            pending <= 1'b0;
        end else if (in_valid && in_ready) begin
            pending  <= 1'b1;
            acc_cyc  <= cyc;
            exp_code <= {in_data, mpar(in_data)};
        end else if (out_valid && out_ready) begin
            pending <= 1'b0;
        end
    end

    // Per-cycle checker: output must be valid exactly K+1 cycles after accept.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("ready_valid_excl", N'(in_ready && out_valid), '0);
            check("in_ready", N'(in_ready), N'(!pending));
            check("busy", N'(busy), N'(pending && (cyc - acc_cyc) <= K));
            check("out_valid", N'(out_valid), N'(pending && (cyc - acc_cyc) > K));
            if (out_valid && pending) check("out_code", out_code, exp_code);
        end
    end

    task automatic accept(input logic [K-1:0] d);
        int n;
        n = 0;
        while (!in_ready && n < 400) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
        end
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = K'({$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic run_word(input logic [K-1:0] d, input int hold, output logic [N-1:0] got);
        int n;
        out_ready = (hold == 0);
        accept(d);
        n = 0;
        while (!out_valid && n < 400) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL out_valid_timeout: out_valid got 0 expected 1");
            got = '0;
            out_ready = 1'b1;
            return;
        end
        got = out_code;
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                in_valid = (i != hold - 1);
                in_data  = K'({$urandom, $urandom, $urandom, $urandom});
                tick();
                check("bp_stable", out_code, got);
                check("bp_valid", N'(out_valid), N'(1));
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        tick();
        check("idle_after_hs", N'(in_ready), N'(1));
    endtask

    logic [K-1:0] vecs [8];
    logic [N-1:0] got;

    initial begin
        vecs[0] = '0;
        vecs[1] = K'(1);
        vecs[2] = K'(2);
        vecs[3] = '1;
        vecs[4] = {64'h5555_5555_5555_5555, 63'h5555_5555_5555_5555};
        vecs[5] = K'(1) << (K - 1);
        vecs[6] = {63'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321};
        vecs[7] = {64'hDEAD_BEEF_CAFE_F00D, 63'h0123_4567_89AB_CDEF};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        chk_en = 1'b1;
        tick();
        check("rst_in_ready", N'(in_ready), N'(1));
        check("rst_out_valid", N'(out_valid), '0);
        check("rst_busy", N'(busy), '0);
        check("rst_out_code", out_code, '0);
        repeat (10) tick();

        check("model_zero", N'(mpar('0)), '0);
        check("model_unit", N'(mpar(K'(1))), N'(14'h0377));
        check("model_x15", N'(mpar(K'(2))), N'(14'h06EE));

        for (int i = 0; i < 8; i++) begin
            run_word(vecs[i], (i == 3) ? 50 : 0, got);
            check("code_vs_model", got, {vecs[i], mpar(vecs[i])});
            if (i == 0) check("zero_code", got, '0);
            if (i == 1) check("unit_code", got, {K'(1), 14'h0377});
            if (i == 2) check("x15_code", got, {K'(2), 14'h06EE});
        end

        accept(K'(3));
        repeat (61) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", N'(in_ready), N'(1));
        check("midrst_out_valid", N'(out_valid), '0);
        check("midrst_busy", N'(busy), '0);
        repeat (5) tick();
        run_word(K'(1), 0, got);
        check("unit_after_rst", got, {K'(1), 14'h0377});

        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
